// File: rtl/acc_buf_ctrl_if.sv
// APB slave bus bundle for acc_buf_ctrl. The bench drives the master side and the
// controller sits on the slave side.
interface acc_buf_ctrl_if #(parameter int APB_ADDR_WIDTH = 14);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                   input  PRDATA, PREADY, PSLVERR);
   modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                   output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/acc_buf_ctrl.sv
// APB-mapped operand/result buffers and start/done sequencing for a 1 KiB accelerator.
// Define ACC_BUF_CTRL_TIMEOUT_EN to build in the BUSY watchdog and TIMEOUT register.
module acc_buf_ctrl #(
   parameter int APB_ADDR_WIDTH = 14
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   acc_buf_ctrl_if.slave     apb,
   output logic              acc_start,
   input  logic              acc_done,
   output logic [1023:0][7:0] acc_in_A,
   output logic [1023:0][7:0] acc_in_B,
   input  logic [1023:0][7:0] acc_out,
   output logic              irq
);
   typedef enum logic [1:0] {IDLE, START, BUSY, CAPTURE} state_t;
   state_t state_q, state_d;

   // word n occupies bits [32n+31:32n], so byte 4n lands in PWDATA[7:0]
   logic [255:0][31:0] buf_a, buf_b, buf_r;
   logic [APB_ADDR_WIDTH-1:0] addr;
   logic [1:0] region;
   logic [7:0] widx;
   logic acc, wr, busy, reg_ctrl, reg_stat, reg_tmo, reg_bad, err, start_ok;
   logic done, tmo, tmo_hit;
   logic unused_bits;

   assign addr        = apb.PADDR;
   assign region      = addr[13:12];
   assign widx        = addr[9:2];
   assign unused_bits = ^{addr[11:10], addr[1:0]};

   assign acc      = apb.PSEL & apb.PENABLE;
   assign wr       = acc & apb.PWRITE;
   assign busy     = (state_q != IDLE);
   assign reg_ctrl = (region == 2'd3) && (widx == 8'd0);
   assign reg_stat = (region == 2'd3) && (widx == 8'd1);
   assign reg_tmo  = (region == 2'd3) && (widx == 8'd2);
   assign reg_bad  = (region == 2'd3) && (widx > 8'd2);

   assign err = acc & (reg_bad | (apb.PWRITE & (((region == 2'd0 || region == 2'd1) && busy) ||
                                                (region == 2'd2) ||
                                                (reg_ctrl && apb.PWDATA[0] && busy))));
   assign start_ok = wr & reg_ctrl & apb.PWDATA[0] & ~busy;

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = err;
   assign acc_in_A    = buf_a;
   assign acc_in_B    = buf_b;
   assign irq         = done | tmo;

`ifdef ACC_BUF_CTRL_TIMEOUT_EN
   logic [15:0] tmo_val, cnt;
   // acc_done in the expiry cycle takes the normal CAPTURE path
   assign tmo_hit = (state_q == BUSY) && !acc_done && (tmo_val != 16'd0) &&
                    (cnt == tmo_val - 16'd1);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         tmo_val <= 16'hFFFF;
         cnt     <= 16'd0;
      end else begin
         if (wr && reg_tmo) tmo_val <= apb.PWDATA[15:0];
         if (state_q == START)     cnt <= 16'd0;
         else if (state_q == BUSY) cnt <= cnt + 16'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      acc_start = 1'b0;
      case (state_q)
         IDLE:    if (start_ok) state_d = START;
         START:   begin acc_start = 1'b1; state_d = BUSY; end
         BUSY:    if (acc_done) state_d = CAPTURE;
                  else if (tmo_hit) state_d = IDLE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         buf_a <= '0;
         buf_b <= '0;
         buf_r <= '0;
         done  <= 1'b0;
         tmo   <= 1'b0;
      end else begin
         if (wr && !busy && region == 2'd0) buf_a[widx] <= apb.PWDATA;
         if (wr && !busy && region == 2'd1) buf_b[widx] <= apb.PWDATA;
         if (state_q == CAPTURE) buf_r <= acc_out;
         if (start_ok) begin
            done <= 1'b0;
            tmo  <= 1'b0;
         end else if (wr && reg_stat) begin
            if (apb.PWDATA[1]) done <= 1'b0;
            if (apb.PWDATA[2]) tmo  <= 1'b0;
         end
         // hardware set outranks a same-cycle software clear
         if (state_q == CAPTURE) done <= 1'b1;
         if (tmo_hit) tmo <= 1'b1;
      end
   end

   always_comb begin
      apb.PRDATA = 32'd0;
      case (region)
         2'd0: apb.PRDATA = buf_a[widx];
         2'd1: apb.PRDATA = buf_b[widx];
         2'd2: apb.PRDATA = buf_r[widx];
         default: begin
            if (reg_stat) apb.PRDATA = {29'd0, tmo, done, busy};
`ifdef ACC_BUF_CTRL_TIMEOUT_EN
            if (reg_tmo)  apb.PRDATA = {16'd0, tmo_val};
`endif
         end
      endcase
   end
endmodule

// File: tb/tb_acc_buf_ctrl.sv
// Directed bench for acc_buf_ctrl: APB buffer access, start/done sequencing, error
// responses, watchdog (either build) and reset abort.
module tb_acc_buf_ctrl;
   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   acc_buf_ctrl_if #(.APB_ADDR_WIDTH(14)) apb();
   logic acc_start, acc_done, irq;
   logic [1023:0][7:0] acc_in_A, acc_in_B, acc_out;

   acc_buf_ctrl #(.APB_ADDR_WIDTH(14)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .apb(apb),
      .acc_start(acc_start), .acc_done(acc_done),
      .acc_in_A(acc_in_A), .acc_in_B(acc_in_B), .acc_out(acc_out), .irq(irq));

   int vectors = 0;
   int errors  = 0;
   int pulses  = 0;

   always @(negedge HCLK) if (acc_start === 1'b1) pulses++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic apb_wr(input logic [13:0] a, input logic [31:0] d, output logic e);
      @(posedge HCLK); #1;
      apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      @(posedge HCLK); #1;
      apb.PENABLE = 1'b1;
      @(negedge HCLK);
      e = apb.PSLVERR;
      @(posedge HCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
   endtask

   task automatic apb_rd(input logic [13:0] a, output logic [31:0] d, output logic e);
      @(posedge HCLK); #1;
      apb.PADDR = a; apb.PWRITE = 1'b0; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      @(posedge HCLK); #1;
      apb.PENABLE = 1'b1;
      @(negedge HCLK);
      d = apb.PRDATA;
      e = apb.PSLVERR;
      @(posedge HCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
   endtask

   // returns on the negedge where acc_start is seen high
   task automatic wait_start(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge HCLK);
         if (acc_start === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e;
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      vectors++; if (acc_start !== 1'b0) begin $display("FAIL rst_start: got %b want 0", acc_start); errors++; end
      vectors++; if (irq !== 1'b0) begin $display("FAIL rst_irq: got %b want 0", irq); errors++; end
      vectors++; if (acc_in_A !== '0) begin $display("FAIL rst_bufA: %0d bits set want 0", $countones(acc_in_A)); errors++; end
      vectors++; if (acc_in_B !== '0) begin $display("FAIL rst_bufB: %0d bits set want 0", $countones(acc_in_B)); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL rst_status: got %h want 0", d); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL rst_result: got %h want 0", d); errors++; end
      apb_rd(14'h3008, d, e);
`ifdef ACC_BUF_CTRL_TIMEOUT_EN
      vectors++; if (d !== 32'h0000FFFF) begin $display("FAIL rst_timeout: got %h want 0000ffff", d); errors++; end
`else
      vectors++; if (d !== 32'h0) begin $display("FAIL rst_timeout: got %h want 0", d); errors++; end
`endif
   endtask

   task automatic test_buf_write;
      logic [31:0] d; logic e; logic [7:0] exp_b;
      apb_wr(14'h0000, 32'h04030201, e);
      vectors++; if (e !== 1'b0) begin $display("FAIL wrA_err: got %b want 0", e); errors++; end
      for (int i = 0; i < 4; i++) begin
         exp_b = 8'(i + 1);
         vectors++; if (acc_in_A[i] !== exp_b) begin $display("FAIL wrA_byte%0d: got %h want %h", i, acc_in_A[i], exp_b); errors++; end
      end
      apb_rd(14'h0000, d, e);
      vectors++; if (d !== 32'h04030201 || e !== 1'b0) begin $display("FAIL rdA: got %h/%b want 04030201/0", d, e); errors++; end
      // bits 11:10 set on the write, clear on the read: must alias
      apb_wr(14'h1FFC, 32'hA1B2C3D4, e);
      vectors++; if (acc_in_B[1023] !== 8'hA1 || acc_in_B[1020] !== 8'hD4) begin $display("FAIL wrB_top: got %h..%h want a1..d4", acc_in_B[1023], acc_in_B[1020]); errors++; end
      apb_rd(14'h13FC, d, e);
      vectors++; if (d !== 32'hA1B2C3D4) begin $display("FAIL rdB_alias: got %h want a1b2c3d4", d); errors++; end
      apb_wr(14'h2000, 32'hFFFFFFFF, e);
      vectors++; if (e !== 1'b1) begin $display("FAIL wrR_err: got %b want 1", e); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h0 || e !== 1'b0) begin $display("FAIL rdR_after_wr: got %h/%b want 0/0", d, e); errors++; end
   endtask

   task automatic test_regs;
      logic [31:0] d; logic e; int p0;
      p0 = pulses;
      apb_rd(14'h300C, d, e);
      vectors++; if (d !== 32'h0 || e !== 1'b1) begin $display("FAIL rd_unmapped: got %h/%b want 0/1", d, e); errors++; end
      apb_wr(14'h3010, 32'h1, e);
      vectors++; if (e !== 1'b1) begin $display("FAIL wr_unmapped: got %b want 1", e); errors++; end
      apb_wr(14'h3000, 32'h0, e);
      vectors++; if (e !== 1'b0) begin $display("FAIL ctrl_zero_err: got %b want 0", e); errors++; end
      apb_rd(14'h3000, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL ctrl_read: got %h want 0", d); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL status_nostart: got %h want 0", d); errors++; end
      vectors++; if (pulses != p0) begin $display("FAIL no_start_pulse: got %0d want 0", pulses - p0); errors++; end
   endtask

   task automatic test_start;
      logic [31:0] d; logic e; logic ok; int p0;
      acc_out = '0;
      acc_out[0] = 8'hEF; acc_out[1] = 8'hBE; acc_out[2] = 8'hAD; acc_out[3] = 8'hDE;
      acc_out[1023] = 8'h12; acc_out[1022] = 8'h34; acc_out[1021] = 8'h56; acc_out[1020] = 8'h78;
      p0 = pulses;
      apb_wr(14'h3000, 32'h1, e);
      vectors++; if (e !== 1'b0) begin $display("FAIL start_err: got %b want 0", e); errors++; end
      wait_start(ok);
      vectors++; if (!ok) begin $display("FAIL start_seen: got 0 want 1"); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h1) begin $display("FAIL status_busy: got %h want 1", d); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL result_old: got %h want 0", d); errors++; end
      repeat (4) @(posedge HCLK);
      #1 acc_done = 1'b1;
      @(posedge HCLK); #1 acc_done = 1'b0;
      repeat (2) @(posedge HCLK);
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h2) begin $display("FAIL status_done: got %h want 2", d); errors++; end
      vectors++; if (irq !== 1'b1) begin $display("FAIL irq_done: got %b want 1", irq); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'hDEADBEEF) begin $display("FAIL result_w0: got %h want deadbeef", d); errors++; end
      apb_rd(14'h23FC, d, e);
      vectors++; if (d !== 32'h12345678) begin $display("FAIL result_w255: got %h want 12345678", d); errors++; end
      vectors++; if (pulses - p0 != 1) begin $display("FAIL start_pulse_cycles: got %0d want 1", pulses - p0); errors++; end
      // acc_done while idle must not disturb anything
      @(posedge HCLK); #1 acc_done = 1'b1;
      repeat (2) @(posedge HCLK); #1 acc_done = 1'b0;
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h2) begin $display("FAIL idle_done_ignored: got %h want 2", d); errors++; end
   endtask

   task automatic test_busy_err;
      logic [31:0] d; logic e; logic ok; int p0;
      acc_out = '0;
      acc_out[0] = 8'h44; acc_out[1] = 8'h33; acc_out[2] = 8'h22; acc_out[3] = 8'h11;
      p0 = pulses;
      apb_wr(14'h3000, 32'h1, e);
      wait_start(ok);
      vectors++; if (!ok) begin $display("FAIL start2_seen: got 0 want 1"); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h1) begin $display("FAIL start_clears_done: got %h want 1", d); errors++; end
      apb_wr(14'h1014, 32'hCAFEF00D, e);
      vectors++; if (e !== 1'b1) begin $display("FAIL wrB_busy_err: got %b want 1", e); errors++; end
      apb_wr(14'h0008, 32'h55555555, e);
      vectors++; if (e !== 1'b1) begin $display("FAIL wrA_busy_err: got %b want 1", e); errors++; end
      apb_wr(14'h3000, 32'h1, e);
      vectors++; if (e !== 1'b1) begin $display("FAIL ctrl_busy_err: got %b want 1", e); errors++; end
      vectors++; if (acc_in_B[23:20] !== 32'h0) begin $display("FAIL bufB_w5_kept: got %h want 0", acc_in_B[23:20]); errors++; end
      vectors++; if (acc_in_A[11:8] !== 32'h0) begin $display("FAIL bufA_w2_kept: got %h want 0", acc_in_A[11:8]); errors++; end
      vectors++; if (acc_in_A[3:0] !== 32'h04030201) begin $display("FAIL bufA_stable: got %h want 04030201", acc_in_A[3:0]); errors++; end
      vectors++; if (pulses - p0 != 1) begin $display("FAIL single_pulse: got %0d want 1", pulses - p0); errors++; end
      // W1C of DONE lands in the CAPTURE cycle
      @(posedge HCLK); #1;
      acc_done = 1'b1;
      apb.PADDR = 14'h3004; apb.PWDATA = 32'h2; apb.PWRITE = 1'b1; apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
      @(posedge HCLK); #1;
      acc_done = 1'b0; apb.PENABLE = 1'b1;
      @(posedge HCLK); #1;
      apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h2) begin $display("FAIL hw_set_wins: got %h want 2", d); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h11223344) begin $display("FAIL result2_w0: got %h want 11223344", d); errors++; end
      apb_wr(14'h3004, 32'h2, e);
      vectors++; if (irq !== 1'b0) begin $display("FAIL irq_w1c: got %b want 0", irq); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL status_w1c: got %h want 0", d); errors++; end
   endtask

   task automatic test_timeout;
      logic [31:0] d; logic e; logic ok; int n;
      acc_out = '0;
      acc_out[3:0] = 32'h99999999;
      apb_wr(14'h3008, 32'h4, e);
      vectors++; if (e !== 1'b0) begin $display("FAIL tmo_wr_err: got %b want 0", e); errors++; end
      apb_rd(14'h3008, d, e);
`ifdef ACC_BUF_CTRL_TIMEOUT_EN
      vectors++; if (d !== 32'h4) begin $display("FAIL tmo_readback: got %h want 4", d); errors++; end
      apb_wr(14'h3000, 32'h1, e);
      wait_start(ok);
      vectors++; if (!ok) begin $display("FAIL tmo_start_seen: got 0 want 1"); errors++; end
      // one START negedge seen; four BUSY negedges follow, irq shows on the fifth
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK); n++;
         if (irq === 1'b1) break;
      end
      vectors++; if (n != 5) begin $display("FAIL tmo_latency: got %0d want 5", n); errors++; end
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h4) begin $display("FAIL tmo_status: got %h want 4", d); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h11223344) begin $display("FAIL tmo_no_capture: got %h want 11223344", d); errors++; end
      apb_wr(14'h3004, 32'h4, e);
      vectors++; if (irq !== 1'b0) begin $display("FAIL tmo_irq_clear: got %b want 0", irq); errors++; end
      apb_wr(14'h3008, 32'hFFFF, e);
`else
      vectors++; if (d !== 32'h0) begin $display("FAIL tmo_reads_zero: got %h want 0", d); errors++; end
      apb_wr(14'h3000, 32'h1, e);
      wait_start(ok);
      vectors++; if (!ok) begin $display("FAIL tmo_start_seen: got 0 want 1"); errors++; end
      repeat (20) @(posedge HCLK);
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h1) begin $display("FAIL no_watchdog_busy: got %h want 1", d); errors++; end
      #1 acc_done = 1'b1;
      @(posedge HCLK); #1 acc_done = 1'b0;
      repeat (2) @(posedge HCLK);
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h2) begin $display("FAIL no_watchdog_done: got %h want 2", d); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h99999999) begin $display("FAIL no_watchdog_capture: got %h want 99999999", d); errors++; end
      apb_wr(14'h3004, 32'h6, e);
`endif
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; logic e; logic ok; int p0;
      apb_wr(14'h3000, 32'h1, e);
      wait_start(ok);
      vectors++; if (!ok) begin $display("FAIL rstmid_start_seen: got 0 want 1"); errors++; end
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b0;
      @(posedge HCLK); #1 HRESETn = 1'b1;
      p0 = pulses;
      acc_done = 1'b1;
      @(posedge HCLK); #1 acc_done = 1'b0;
      repeat (3) @(posedge HCLK);
      apb_rd(14'h3004, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL rstmid_status: got %h want 0", d); errors++; end
      vectors++; if (irq !== 1'b0) begin $display("FAIL rstmid_irq: got %b want 0", irq); errors++; end
      vectors++; if (acc_start !== 1'b0) begin $display("FAIL rstmid_start: got %b want 0", acc_start); errors++; end
      vectors++; if (acc_in_A !== '0) begin $display("FAIL rstmid_bufA: %0d bits set want 0", $countones(acc_in_A)); errors++; end
      vectors++; if (acc_in_B !== '0) begin $display("FAIL rstmid_bufB: %0d bits set want 0", $countones(acc_in_B)); errors++; end
      apb_rd(14'h2000, d, e);
      vectors++; if (d !== 32'h0) begin $display("FAIL rstmid_result: got %h want 0", d); errors++; end
      vectors++; if (pulses != p0) begin $display("FAIL rstmid_pulses: got %0d want 0", pulses - p0); errors++; end
   endtask

   initial begin
      apb.PADDR = '0; apb.PWDATA = '0; apb.PWRITE = 1'b0; apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
      acc_done = 1'b0;
      acc_out  = '0;
      test_reset;
      test_buf_write;
      test_regs;
      test_start;
      test_busy_err;
      test_timeout;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/acc_buf_ctrl.md
ACC_BUF_CTRL -- requirements
Module: acc_buf_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 14, APB address width; only PADDR[13:0] is decoded.
REQ-002 SHALL have ports: HCLK  in  1  clock; HRESETn  in  1  reset, asynchronous, active-low (already decided).
REQ-003 SHALL have APB ports: PADDR in APB_ADDR_WIDTH; PWDATA in 32; PWRITE, PSEL, PENABLE in 1; PRDATA out 32; PREADY, PSLVERR out 1.
REQ-004 SHALL have accelerator ports: acc_start  out  1  start pulse; acc_done  in  1  completion; acc_in_A, acc_in_B  out  1024x8  operand buffers; acc_out  in  1024x8  result.
REQ-005 SHALL have irq  out  1  level interrupt, high while STATUS.DONE or STATUS.TMO is set.

Function
REQ-006 Address map SHALL be selected by PADDR[13:12]: 0 = A buffer, 1 = B buffer, 2 = result buffer (read-only), 3 = registers; word index = PADDR[9:2]; PADDR[11:10] ignored.
REQ-007 Word n SHALL map to bytes 4n..4n+3, little-endian (PWDATA[7:0] -> byte 4n).
REQ-008 Registers: 0x3000 CTRL (write bit0=1 -> start; reads 0); 0x3004 STATUS (bit0 BUSY, bit1 DONE, bit2 TMO; write-1-to-clear bits 1..2); 0x3008 TIMEOUT (16-bit, see Configuration).
REQ-009 Transfer SHALL complete on PSEL & PENABLE; PREADY SHALL be constant 1 (zero wait states).
REQ-010 PSLVERR SHALL be 1 in the access phase for: write to A/B while BUSY; write to result region; CTRL start while BUSY; unmapped register offset. Erroneous writes SHALL have no effect.
REQ-011 PRDATA SHALL be combinational from the decoded address; unmapped reads return 0.
REQ-012 FSM states IDLE, START, BUSY, CAPTURE.
REQ-013 IDLE -> START on a valid CTRL start write; START SHALL drive acc_start=1 for exactly one cycle, then -> BUSY.
REQ-014 BUSY -> CAPTURE when acc_done=1; CAPTURE SHALL latch acc_out into the result buffer in one cycle, set DONE, then -> IDLE.
REQ-015 STATUS.BUSY SHALL read 1 in START, BUSY and CAPTURE.
REQ-016 A start write SHALL clear DONE and TMO in the same cycle it is accepted.
REQ-017 acc_done in IDLE or START SHALL be ignored.
REQ-018 Result buffer SHALL hold the previous result until the next CAPTURE; reads during BUSY return old data.
REQ-019 acc_in_A/acc_in_B SHALL be driven directly from the buffers and stay stable from START through CAPTURE.
REQ-020 Software W1C of DONE in the same cycle as CAPTURE SHALL leave DONE set (hardware set wins).

Reset
REQ-021 On HRESETn low: state IDLE, acc_start 0, STATUS 0, irq 0, A/B/result buffers all 0, TIMEOUT 0xFFFF, cycle counter 0.
REQ-022 Reset mid-operation SHALL abort immediately; a subsequent acc_done SHALL be ignored until a new start.

Configuration
REQ-023 Macro ACC_BUF_CTRL_TIMEOUT_EN SHALL compile in the busy watchdog.
REQ-024 With it: 16-bit counter clears on entering BUSY and increments each BUSY cycle; when counter == TIMEOUT-1 and acc_done=0, -> IDLE, set TMO, result not captured; TIMEOUT=0 disables the watchdog; acc_done in the expiry cycle wins (normal CAPTURE).
REQ-025 Without it: TIMEOUT reads 0 and writes are accepted without error and ignored; TMO always 0; BUSY waits indefinitely.

Verification
REQ-026 Write A word 0 = 0x04030201 -> acc_in_A bytes 0..3 = 01,02,03,04; read back 0x04030201, PSLVERR 0.
REQ-027 Start write, acc_done raised 10 cycles after acc_start -> acc_start high exactly 1 cycle; STATUS = 0x1 during wait, 0x2 after CAPTURE; irq 1; result word 0 equals acc_out bytes 0..3.
REQ-028 Write B word 5 and CTRL start while BUSY -> PSLVERR 1 both; B buffer unchanged; single acc_start pulse observed.
REQ-029 With macro, TIMEOUT=4, acc_done never raised -> exit BUSY after 4 cycles, STATUS = 0x4, result buffer unchanged; write STATUS 0x4 -> irq 0.
REQ-030 Assert HRESETn low two cycles into BUSY, then pulse acc_done -> STATUS 0, all buffers 0, no CAPTURE, acc_start 0.
